// File: rtl/ula_pkg.sv
// Shared encodings and request record for the ULA arbiter and its clients.
package ula_pkg;

  localparam logic [1:0] ORIG_R   = 2'b00;
  localparam logic [1:0] ORIG_I   = 2'b01;
  localparam logic [1:0] ORIG_CMP = 2'b10;

  localparam logic [2:0] SEL_PASS = 3'd0;
  localparam logic [2:0] SEL_ADD  = 3'd1;
  localparam logic [2:0] SEL_SUB  = 3'd2;
  localparam logic [2:0] SEL_MUL  = 3'd3;
  localparam logic [2:0] SEL_DIV  = 3'd4;
  localparam logic [2:0] SEL_AND  = 3'd5;
  localparam logic [2:0] SEL_OR   = 3'd6;
  localparam logic [2:0] SEL_NEG  = 3'd7;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  typedef struct packed {
    logic [2:0]  selec;
    logic [1:0]  orig;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] rd;
    logic [31:0] imed;
  } ula_req_t;

  // Only R-type mul/div need the long settle window.
  function automatic logic is_muldiv(input ula_req_t q);
    return (q.orig == ORIG_R) && ((q.selec == SEL_MUL) || (q.selec == SEL_DIV));
  endfunction

endpackage

// File: rtl/ula_arbiter_rr_arb2.sv
// Two-way round-robin grant: the pointed-to requester wins when valid.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       ptr,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (valid[ptr])       grant[ptr]  = 1'b1;
    else if (valid[~ptr]) grant[~ptr] = 1'b1;
  end

endmodule

// File: rtl/ula_arbiter.sv
// Time-shares one combinational ULA between execute (0) and branch-compare (1),
// holding registered operands for a per-op settle window before capturing.
module ula_arbiter
  import ula_pkg::*;
#(
  parameter int unsigned LAT_MULDIV = 3,
  parameter int unsigned LAT_BASE   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [1:0][2:0]  req_selec,
  input  logic [1:0][1:0]  req_orig,
  input  logic [1:0][31:0] req_rs,
  input  logic [1:0][31:0] req_rt,
  input  logic [1:0][31:0] req_rd,
  input  logic [1:0][31:0] req_imed,
  output logic [1:0]       resp_valid,
  input  logic [1:0]       resp_ready,
  output logic [31:0]      resp_result,
  output logic             resp_zero,
  output logic             resp_neg,
  output logic [2:0]       ula_selec,
  output logic [1:0]       ula_orig,
  output logic [31:0]      ula_rs,
  output logic [31:0]      ula_rt,
  output logic [31:0]      ula_rd,
  output logic [31:0]      ula_imed,
  input  logic [31:0]      ula_result,
  input  logic             ula_zero,
  input  logic             ula_neg
);

  localparam int unsigned LAT_MAX = (LAT_MULDIV > LAT_BASE) ? LAT_MULDIV : LAT_BASE;
  localparam int CW = $clog2(LAT_MAX + 1);

  state_t          state, state_nx;
  logic            ptr, gnt_idx, win, accept;
  logic [1:0]      grant;
  logic [CW-1:0]   cnt;
  ula_req_t        op;
  ula_req_t [1:0]  reqs;

  for (genvar i = 0; i < 2; i++) begin : g_req
    assign reqs[i] = {req_selec[i], req_orig[i], req_rs[i], req_rt[i], req_rd[i], req_imed[i]};
  end

  rr_arb2 u_rr (.valid(req_valid), .ptr(ptr), .grant(grant));

  assign win = grant[1];

  always_comb begin
    state_nx   = state;
    req_ready  = 2'b00;
    resp_valid = 2'b00;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        // Gate with rst so ready stays low while reset is held.
        req_ready = rst ? 2'b00 : grant;
        accept    = |grant;
        if (accept) state_nx = EXEC;
      end
      EXEC: if (cnt == CW'(1)) state_nx = RESP;
      RESP: begin
        resp_valid[gnt_idx] = 1'b1;
        if (resp_ready[gnt_idx]) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= 1'b0;
      gnt_idx     <= 1'b0;
      cnt         <= '0;
      op          <= '0;
      resp_result <= '0;
      resp_zero   <= 1'b0;
      resp_neg    <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        op      <= reqs[win];
        gnt_idx <= win;
        ptr     <= ~win;
        cnt     <= is_muldiv(reqs[win]) ? CW'(LAT_MULDIV) : CW'(LAT_BASE);
      end else if (state == EXEC) begin
        cnt <= cnt - CW'(1);
        if (cnt == CW'(1)) begin
          resp_result <= ula_result;
          resp_zero   <= ula_zero;
          resp_neg    <= ula_neg;
        end
      end
    end
  end

  assign ula_selec = op.selec;
  assign ula_orig  = op.orig;
  assign ula_rs    = op.rs;
  assign ula_rt    = op.rt;
  assign ula_rd    = op.rd;
  assign ula_imed  = op.imed;

endmodule

// File: tb/tb_ula_arbiter.sv
// Randomized self-checking bench: a behavioural ULA sits on the ula_* bus and
// a transaction-level model predicts grant order, latency and returned result.
module tb_ula_arbiter;
  import ula_pkg::*;

  localparam int LMD = 3;
  localparam int LB  = 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       req_valid, req_ready, resp_valid, resp_ready;
  logic [1:0][2:0]  req_selec;
  logic [1:0][1:0]  req_orig;
  logic [1:0][31:0] req_rs, req_rt, req_rd, req_imed;
  logic [31:0]      resp_result;
  logic             resp_zero, resp_neg;
  logic [2:0]       ula_selec;
  logic [1:0]       ula_orig;
  logic [31:0]      ula_rs, ula_rt, ula_rd, ula_imed, ula_result;
  logic             ula_zero, ula_neg;
  ula_req_t         cur;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int ptr_m = 0;

  ula_arbiter #(.LAT_MULDIV(LMD), .LAT_BASE(LB)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_selec(req_selec), .req_orig(req_orig),
    .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd), .req_imed(req_imed),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_result(resp_result), .resp_zero(resp_zero), .resp_neg(resp_neg),
    .ula_selec(ula_selec), .ula_orig(ula_orig),
    .ula_rs(ula_rs), .ula_rt(ula_rt), .ula_rd(ula_rd), .ula_imed(ula_imed),
    .ula_result(ula_result), .ula_zero(ula_zero), .ula_neg(ula_neg)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural ULA: anything outside the known encodings yields 0.
  function automatic logic [31:0] ula_fn(input ula_req_t q);
    case (q.orig)
      ORIG_R: case (q.selec)
        SEL_PASS: return q.rt;
        SEL_ADD:  return q.rt + q.rd;
        SEL_SUB:  return q.rt - q.rd;
        SEL_MUL:  return q.rt * q.rd;
        SEL_DIV:  return (q.rd == 0) ? 32'd0 : q.rt / q.rd;
        SEL_AND:  return q.rt & q.rd;
        SEL_OR:   return q.rt | q.rd;
        default:  return -q.rt;
      endcase
      ORIG_I:   return (q.selec == SEL_ADD) ? q.rs + q.imed : 32'd0;
      ORIG_CMP: return (q.selec == SEL_ADD) ? q.rs - q.rt : 32'd0;
      default:  return 32'd0;
    endcase
  endfunction

  assign cur        = {ula_selec, ula_orig, ula_rs, ula_rt, ula_rd, ula_imed};
  assign ula_result = ula_fn(cur);
  assign ula_zero   = (ula_result == 32'd0);
  assign ula_neg    = ula_result[31];

  function automatic int lat_of(input ula_req_t q);
    return (q.orig == 2'b00 && (q.selec == 3'd3 || q.selec == 3'd4)) ? LMD : LB;
  endfunction

  function automatic ula_req_t mk(input logic [2:0] s, input logic [1:0] o,
                                  input logic [31:0] rs, input logic [31:0] rt,
                                  input logic [31:0] rd, input logic [31:0] im);
    ula_req_t q;
    q.selec = s; q.orig = o; q.rs = rs; q.rt = rt; q.rd = rd; q.imed = im;
    return q;
  endfunction

  function automatic ula_req_t rand_req();
    ula_req_t q;
    q.selec = 3'($urandom_range(0, 7));
    q.orig  = 2'($urandom_range(0, 3));
    q.rs    = $urandom;
    q.rt    = $urandom;
    q.rd    = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 1000));
    q.imed  = $urandom;
    return q;
  endfunction

  task automatic drive(input int r, input ula_req_t q);
    req_selec[r] = q.selec; req_orig[r] = q.orig;
    req_rs[r] = q.rs; req_rt[r] = q.rt; req_rd[r] = q.rd; req_imed[r] = q.imed;
  endtask

  task automatic apply_reset();
    rst = 1'b1; req_valid = 2'b00; resp_ready = 2'b00;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    ptr_m = 0;
  endtask

  // One full transaction: arbitration, hold, capture, backpressure, release.
  task automatic serve(input logic [1:0] v, input ula_req_t q0, input ula_req_t q1,
                       input int hold, input bit keep, input string tag);
    ula_req_t    q[2];
    int          w, acc, lat;
    bit          got;
    logic [1:0]  eg;
    logic [31:0] er;
    q[0] = q0; q[1] = q1;
    drive(0, q0); drive(1, q1);
    req_valid = v; resp_ready = 2'b00;
    w  = v[ptr_m] ? ptr_m : 1 - ptr_m;
    eg = 2'b01 << w;
    #2;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (req_ready != 2'b00) begin got = 1'b1; break; end
      @(posedge clk); #3;
    end
    n_cmp++;
    if (!got || req_ready !== eg) begin
      n_err++;
      $display("FAIL %s grant: req_ready=%b want=%b", tag, req_ready, eg);
      req_valid = 2'b00;
      return;
    end
    @(posedge clk); #1;
    acc = cyc;
    ptr_m = 1 - w;
    if (!keep) begin
      req_valid = 2'b00;
      drive(0, rand_req()); drive(1, rand_req());
    end
    lat = lat_of(q[w]);
    er  = ula_fn(q[w]);
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (resp_valid != 2'b00) begin got = 1'b1; break; end
      n_cmp++;
      if (cur !== q[w] || req_ready !== 2'b00) begin
        n_err++;
        $display("FAIL %s exec_hold: ula=%h want=%h req_ready=%b", tag, cur, q[w], req_ready);
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (!got || resp_valid !== eg || cyc != acc + lat) begin
      n_err++;
      $display("FAIL %s latency: resp_valid=%b want=%b cycles=%0d want=%0d", tag, resp_valid, eg, cyc - acc, lat);
      apply_reset();
      return;
    end
    n_cmp++;
    if (resp_result !== er || resp_zero !== (er == 0) || resp_neg !== er[31]) begin
      n_err++;
      $display("FAIL %s result: got %h z%b n%b want %h z%b n%b", tag, resp_result, resp_zero, resp_neg, er, (er == 0), er[31]);
    end
    // The loser's resp_ready is raised on purpose: it must not release us.
    resp_ready = ~eg;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #2;
      n_cmp++;
      if (resp_valid !== eg || resp_result !== er || req_ready !== 2'b00 || cur !== q[w]) begin
        n_err++;
        $display("FAIL %s backpressure: resp_valid=%b result=%h req_ready=%b want %b %h 00", tag, resp_valid, resp_result, req_ready, eg, er);
      end
    end
    resp_ready = eg;
    @(posedge clk); #2;
    resp_ready = 2'b00;
    n_cmp++;
    if (resp_valid !== 2'b00 || cur !== q[w]) begin
      n_err++;
      $display("FAIL %s release: resp_valid=%b ula=%h want 00 %h", tag, resp_valid, cur, q[w]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 2'b00; resp_ready = 2'b00;
    drive(0, '0); drive(1, '0);
    #3;
    n_cmp++;
    if ({cur, resp_result, resp_zero, resp_neg, resp_valid, req_ready} !== '0) begin
      n_err++;
      $display("FAIL reset_values: ula=%h result=%h valid=%b ready=%b want all 0", cur, resp_result, resp_valid, req_ready);
    end
    @(posedge clk); #1 rst = 1'b0;
    #1 req_valid = 2'b11;
    #1;
    n_cmp++;
    if (req_ready !== 2'b01) begin
      n_err++;
      $display("FAIL reset_pointer: req_ready=%b want 01", req_ready);
    end
    req_valid = 2'b00;
    ptr_m = 0;
  endtask

  task automatic test_add();
    serve(2'b01, mk(SEL_ADD, ORIG_R, 0, 5, 7, 0), rand_req(), 0, 0, "add");
  endtask

  task automatic test_simultaneous();
    ula_req_t a, b;
    apply_reset();
    a = mk(SEL_SUB, ORIG_R, 0, 9, 20, 0);
    b = mk(SEL_OR, ORIG_R, 0, 32'hF0, 32'h0F, 0);
    for (int k = 0; k < 4; k++) serve(2'b11, a, b, 0, (k < 3), "simul");
  endtask

  task automatic test_div();
    serve(2'b10, rand_req(), mk(SEL_DIV, ORIG_R, 0, 10, 2, 0), 0, 0, "div");
  endtask

  task automatic test_backpressure();
    ula_req_t a, b;
    a = mk(SEL_ADD, ORIG_CMP, 3, 5, 0, 0);
    b = mk(SEL_MUL, ORIG_R, 0, 6, 7, 0);
    serve(2'b11, a, b, 5, 1, "backpressure");
    serve(2'b10, a, b, 0, 0, "after_bp");
  endtask

  task automatic test_reset_mid();
    ula_req_t d;
    bit got;
    d = mk(SEL_DIV, ORIG_R, 0, 100, 7, 0);
    drive(0, d);
    req_valid = 2'b01;
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (req_ready[0]) begin got = 1'b1; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1 req_valid = 2'b00;
    @(posedge clk); #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (!got || {cur, resp_result, resp_zero, resp_neg, resp_valid, req_ready} !== '0) begin
      n_err++;
      $display("FAIL reset_mid: granted=%b ula=%h result=%h valid=%b want all 0", got, cur, resp_result, resp_valid);
    end
    @(posedge clk); #1 rst = 1'b0;
    ptr_m = 0;
    for (int i = 0; i < LMD + 2; i++) begin
      @(posedge clk); #2;
      n_cmp++;
      if (resp_valid !== 2'b00) begin
        n_err++;
        $display("FAIL reset_mid_drop: resp_valid=%b want 00", resp_valid);
      end
    end
    serve(2'b01, d, rand_req(), 1, 0, "reissue");
  endtask

  task automatic test_div_zero();
    serve(2'b01, mk(SEL_DIV, ORIG_R, 0, 1234, 0, 0), rand_req(), 0, 0, "div0");
  endtask

  task automatic test_random();
    for (int k = 0; k < 40; k++) begin
      serve(2'($urandom_range(1, 3)), rand_req(), rand_req(),
            $urandom_range(0, 3), 0, "random");
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_simultaneous();
    test_div();
    test_backpressure();
    test_reset_mid();
    test_div_zero();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
